// File: rtl/alu_sequencer.sv
// ---------------------------------------------------------------------------
// alu_sequencer
//
// Control-side partner of the ALU. Fetches 9-bit instructions from a
// synchronous instruction ROM, decodes them, launches operands and an opcode
// into the ALU, then samples the ALU result/exit flag and writes back into an
// internal 8x8 register file (r0 is the accumulator). Every instruction
// takes exactly four cycles: FETCH -> DECODE -> EXECUTE -> WRITEBACK.
//
// Instruction word:
//   [8:5] opcode
//   [4:0] imm5  (opcode 5 only)
//   [2:0] rs    (all other opcodes; [4:3] ignored)
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   imem_addr  instruction address (registered, equal to the PC)
//   imem_data  instruction word, valid one cycle after imem_addr changes
//   op1, op2   ALU operands (registered)
//   operation  ALU opcode (registered, 13 = no-op)
//   result     ALU result, sampled in WRITEBACK
//   exit       ALU exit flag, sampled in WRITEBACK
//   halted     sticky, set once exit has been seen, cleared only by rst
//   dbg_sel    register index for the debug read port
//   dbg_data   combinational read of r[dbg_sel]
// ---------------------------------------------------------------------------
module alu_sequencer #(
    parameter int PC_W  = 8,
    parameter int NREGS = 8
) (
    input  logic            clk,
    input  logic            rst,
    output logic [PC_W-1:0] imem_addr,
    input  logic [8:0]      imem_data,
    output logic [7:0]      op1,
    output logic [7:0]      op2,
    output logic [3:0]      operation,
    input  logic [7:0]      result,
    input  logic            exit,
    output logic            halted,
    input  logic [2:0]      dbg_sel,
    output logic [7:0]      dbg_data
);

    localparam logic [2:0] ST_FETCH     = 3'd0;
    localparam logic [2:0] ST_DECODE    = 3'd1;
    localparam logic [2:0] ST_EXECUTE   = 3'd2;
    localparam logic [2:0] ST_WRITEBACK = 3'd3;
    localparam logic [2:0] ST_HALT      = 3'd4;

    localparam logic [3:0] OP_NOP   = 4'd13;
    localparam logic [3:0] OP_IMM   = 4'd5;
    localparam logic [3:0] OP_STORE = 4'd7;
    localparam logic [3:0] OP_JNZ   = 4'd14;
    localparam logic [3:0] OP_RSVD  = 4'd15;

    logic [2:0]      state_reg;
    logic [PC_W-1:0] pc_reg;
    logic [PC_W-1:0] pc_next;
    logic [8:0]      ir_reg;
    logic [7:0]      r0_val_reg;
    logic [7:0]      rs_val_reg;
    logic [7:0]      op1_reg;
    logic [7:0]      op2_reg;
    logic [3:0]      operation_reg;
    logic            halted_reg;

    logic [7:0]       regs_reg [NREGS];
    logic [NREGS-1:0] reg_we;

    logic [3:0] opcode;
    logic [2:0] rs;
    logic [4:0] imm5;
    logic       wb_commit;
    logic       writes_r0;
    logic       is_store;

    assign opcode = ir_reg[8:5];
    assign rs     = ir_reg[2:0];
    assign imm5   = ir_reg[4:0];

    // A WRITEBACK with exit raised commits nothing: no register write and
    // no PC change.
    assign wb_commit = (state_reg == ST_WRITEBACK) && !exit;
    assign writes_r0 = (opcode <= 4'd6) || ((opcode >= 4'd8) && (opcode <= 4'd11));
    assign is_store  = (opcode == OP_STORE);

    // Per-register write enables. A store with rs = 0 lands in r0.
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_we
        if (gi == 0) begin : g_acc
            assign reg_we[gi] = wb_commit && (writes_r0 || (is_store && (rs == 3'd0)));
        end else begin : g_gpr
            assign reg_we[gi] = wb_commit && is_store && (rs == 3'(gi));
        end
    end

    // Register file. Kept in flops because every entry must clear on reset
    // and the debug port reads it combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (reg_we[i]) begin
                    regs_reg[i] <= result;
                end
            end
        end
    end

    // Jump-if-r0-nonzero uses the r0/rs values captured in DECODE; no write
    // can happen between DECODE and WRITEBACK, so they are still current.
    always_comb begin
        pc_next = pc_reg + PC_W'(1);
        if ((opcode == OP_JNZ) && (r0_val_reg != 8'd0)) begin
            pc_next = PC_W'(rs_val_reg);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_FETCH;
            pc_reg        <= '0;
            ir_reg        <= '0;
            r0_val_reg    <= '0;
            rs_val_reg    <= '0;
            op1_reg       <= '0;
            op2_reg       <= '0;
            operation_reg <= OP_NOP;
            halted_reg    <= 1'b0;
        end else begin
            case (state_reg)
                ST_FETCH: begin
                    // The ROM samples imem_addr (= PC) on this edge.
                    state_reg <= ST_DECODE;
                end
                ST_DECODE: begin
                    ir_reg     <= imem_data;
                    r0_val_reg <= regs_reg[0];
                    rs_val_reg <= regs_reg[imem_data[2:0]];
                    state_reg  <= ST_EXECUTE;
                end
                ST_EXECUTE: begin
                    op1_reg       <= r0_val_reg;
                    op2_reg       <= rs_val_reg;
                    operation_reg <= opcode;
                    case (opcode)
                        OP_IMM: begin
                            op2_reg <= {3'b000, imm5};
                        end
                        OP_STORE: begin
                            // Route r0 through the ALU's pass-op2 path.
                            op2_reg       <= r0_val_reg;
                            operation_reg <= OP_IMM;
                        end
                        OP_RSVD: begin
                            operation_reg <= OP_NOP;
                        end
                        default: begin
                        end
                    endcase
                    state_reg <= ST_WRITEBACK;
                end
                ST_WRITEBACK: begin
                    // Operands stay put here so the ALU sees a stable launch.
                    if (exit) begin
                        halted_reg    <= 1'b1;
                        operation_reg <= OP_NOP;
                        state_reg     <= ST_HALT;
                    end else begin
                        pc_reg    <= pc_next;
                        state_reg <= ST_FETCH;
                    end
                end
                ST_HALT: begin
                    state_reg <= ST_HALT;
                end
                default: begin
                    state_reg <= ST_FETCH;
                end
            endcase
        end
    end

    assign imem_addr = pc_reg;
    assign op1       = op1_reg;
    assign op2       = op2_reg;
    assign operation = operation_reg;
    assign halted    = halted_reg;
    assign dbg_data  = regs_reg[dbg_sel];

endmodule
